// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the I/D memory port arbiter.
// The optional ARB_PERF_CNT_EN build adds grant/conflict counters to the top.
package mem_arb_pkg;
  localparam int DATA_W_DEF     = 32;
  localparam int STRB_W         = DATA_W_DEF / 8;
  localparam int STARVE_CNT_MAX = 15;
  localparam int STARVE_CNT_W   = 4;

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2} arb_state_e;
  typedef enum logic [1:0] {OWN_NONE = 2'd0, OWN_I = 2'd1, OWN_D = 2'd2} arb_owner_e;

  function automatic int strb_w(input int data_w);
    return data_w / 8;
  endfunction
endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester (I/D) and memory-side signals of mem_port_arbiter.
// slave = arbiter view, master = the surrounding core/memory view.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int SW = DATA_W / 8;

  logic              iReqValid;
  logic [ADDR_W-1:0] iReqAddr;
  logic              iReqReady;
  logic              iRespValid;
  logic [DATA_W-1:0] iRespData;
  logic [ADDR_W-1:0] iRespAddr;

  logic              dReqValid;
  logic [ADDR_W-1:0] dReqAddr;
  logic              dReqWe;
  logic [DATA_W-1:0] dReqWdata;
  logic [SW-1:0]     dReqWstrb;
  logic              dReqReady;
  logic              dRespValid;
  logic [DATA_W-1:0] dRespData;
  logic [ADDR_W-1:0] dRespAddr;

  logic              memReqValid;
  logic [ADDR_W-1:0] memAddr;
  logic              memWe;
  logic [DATA_W-1:0] memWdata;
  logic [SW-1:0]     memWstrb;
  logic              memReady;
  logic              memRespValid;
  logic [DATA_W-1:0] memRespData;

  modport slave (
    input  iReqValid, iReqAddr,
    output iReqReady, iRespValid, iRespData, iRespAddr,
    input  dReqValid, dReqAddr, dReqWe, dReqWdata, dReqWstrb,
    output dReqReady, dRespValid, dRespData, dRespAddr,
    output memReqValid, memAddr, memWe, memWdata, memWstrb,
    input  memReady, memRespValid, memRespData
  );

  modport master (
    output iReqValid, iReqAddr,
    input  iReqReady, iRespValid, iRespData, iRespAddr,
    output dReqValid, dReqAddr, dReqWe, dReqWdata, dReqWstrb,
    input  dReqReady, dRespValid, dRespData, dRespAddr,
    input  memReqValid, memAddr, memWe, memWdata, memWstrb,
    output memReady, memRespValid, memRespData
  );
endinterface

// File: rtl/mem_port_arbiter_prio.sv
// D-priority winner selection with a starvation guard that forces I through
// after STARVE_LIMIT consecutive D grants while I waits.
module arb_priority_sel
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic                    i_i_valid,
  input  logic                    i_d_valid,
  input  logic [STARVE_CNT_W-1:0] i_starve_cnt,
  input  logic                    i_grant_en,
  output logic                    o_gnt_i,
  output logic                    o_gnt_d,
  output logic [STARVE_CNT_W-1:0] o_starve_nxt
);
  logic w_i_forced;

  assign w_i_forced = i_i_valid && (int'(i_starve_cnt) >= STARVE_LIMIT);
  assign o_gnt_i    = i_grant_en && i_i_valid && (!i_d_valid || w_i_forced);
  assign o_gnt_d    = i_grant_en && i_d_valid && !o_gnt_i;

  always_comb begin
    o_starve_nxt = i_starve_cnt;
    if (o_gnt_i || (o_gnt_d && !i_i_valid))
      o_starve_nxt = '0;
    else if (o_gnt_d && (i_starve_cnt != STARVE_CNT_W'(STARVE_CNT_MAX)))
      o_starve_nxt = i_starve_cnt + 1'b1;
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between fetch (I) and load/store (D), one
// transaction in flight. Define ARB_PERF_CNT_EN for grant/conflict counters.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input logic clk,
  input logic rst_n,
  mem_port_arbiter_if.slave bus
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [31:0] iGrantCnt,
  output logic [31:0] dGrantCnt,
  output logic [31:0] conflictCnt
`endif
);
  localparam int SW = strb_w(DATA_W);

  arb_state_e              r_state, w_state_nxt;
  arb_owner_e              r_owner;
  logic [STARVE_CNT_W-1:0] r_starve, w_starve_nxt;
  logic                    w_gnt_i, w_gnt_d, w_accept, w_resp_take;

  logic [ADDR_W-1:0] r_addr;
  logic              r_we;
  logic [DATA_W-1:0] r_wdata;
  logic [SW-1:0]     r_wstrb;

  logic              r_i_vld, r_d_vld;
  logic [DATA_W-1:0] r_i_data, r_d_data;
  logic [ADDR_W-1:0] r_i_addr, r_d_addr;

  // Grants are gated by rst_n so readies read 0 while reset is held.
  arb_priority_sel #(.STARVE_LIMIT(STARVE_LIMIT)) u_sel (
    .i_i_valid   (bus.iReqValid),
    .i_d_valid   (bus.dReqValid),
    .i_starve_cnt(r_starve),
    .i_grant_en  (rst_n && (r_state == IDLE)),
    .o_gnt_i     (w_gnt_i),
    .o_gnt_d     (w_gnt_d),
    .o_starve_nxt(w_starve_nxt)
  );

  assign w_accept    = w_gnt_i | w_gnt_d;
  assign w_resp_take = bus.memRespValid &&
                       ((r_state == WAIT) || ((r_state == ISSUE) && bus.memReady));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (w_accept) w_state_nxt = ISSUE;
      ISSUE:   if (bus.memReady) w_state_nxt = bus.memRespValid ? IDLE : WAIT;
      WAIT:    if (bus.memRespValid) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.iReqReady   = w_gnt_i;
    bus.dReqReady   = w_gnt_d;
    bus.memReqValid = (r_state == ISSUE);
    bus.memAddr     = r_addr;
    bus.memWe       = r_we;
    bus.memWdata    = r_wdata;
    bus.memWstrb    = r_wstrb;
    bus.iRespValid  = r_i_vld;
    bus.iRespData   = r_i_data;
    bus.iRespAddr   = r_i_addr;
    bus.dRespValid  = r_d_vld;
    bus.dRespData   = r_d_data;
    bus.dRespAddr   = r_d_addr;
  end

  // Fetches are word-aligned reads; the latched request is held through ISSUE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve <= '0;
      r_owner  <= OWN_NONE;
      r_addr   <= '0;
      r_we     <= 1'b0;
      r_wdata  <= '0;
      r_wstrb  <= '0;
    end else begin
      r_starve <= w_starve_nxt;
      if (w_gnt_i) begin
        r_owner <= OWN_I;
        r_addr  <= bus.iReqAddr & ~ADDR_W'(3);
        r_we    <= 1'b0;
        r_wdata <= '0;
        r_wstrb <= '0;
      end else if (w_gnt_d) begin
        r_owner <= OWN_D;
        r_addr  <= bus.dReqAddr;
        r_we    <= bus.dReqWe;
        r_wdata <= bus.dReqWdata;
        r_wstrb <= bus.dReqWstrb;
      end else if (w_resp_take) begin
        r_owner <= OWN_NONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_i_vld  <= 1'b0;
      r_d_vld  <= 1'b0;
      r_i_data <= '0;
      r_d_data <= '0;
      r_i_addr <= '0;
      r_d_addr <= '0;
    end else begin
      r_i_vld <= w_resp_take && (r_owner == OWN_I);
      r_d_vld <= w_resp_take && (r_owner == OWN_D);
      if (w_resp_take && (r_owner == OWN_I)) begin
        r_i_data <= bus.memRespData;
        r_i_addr <= r_addr;
      end
      if (w_resp_take && (r_owner == OWN_D)) begin
        r_d_data <= r_we ? '0 : bus.memRespData;
        r_d_addr <= r_addr;
      end
    end
  end

`ifdef ARB_PERF_CNT_EN
  logic [31:0] r_i_gnt_cnt, r_d_gnt_cnt, r_conflict_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_i_gnt_cnt    <= '0;
      r_d_gnt_cnt    <= '0;
      r_conflict_cnt <= '0;
    end else begin
      if (w_gnt_i) r_i_gnt_cnt <= r_i_gnt_cnt + 32'd1;
      if (w_gnt_d) r_d_gnt_cnt <= r_d_gnt_cnt + 32'd1;
      if ((r_state == IDLE) && bus.iReqValid && bus.dReqValid)
        r_conflict_cnt <= r_conflict_cnt + 32'd1;
    end
  end

  assign iGrantCnt   = r_i_gnt_cnt;
  assign dGrantCnt   = r_d_gnt_cnt;
  assign conflictCnt = r_conflict_cnt;
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a random
// two-requester run checked against a transaction-level reference model.
module tb_mem_port_arbiter;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int LIM    = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

`ifdef ARB_PERF_CNT_EN
  logic [31:0] iGrantCnt, dGrantCnt, conflictCnt;
`endif

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(LIM)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
`ifdef ARB_PERF_CNT_EN
    ,
    .iGrantCnt  (iGrantCnt),
    .dGrantCnt  (dGrantCnt),
    .conflictCnt(conflictCnt)
`endif
  );

  int checks = 0;
  int failures = 0;

  // Memory model: memReady after ready_delay ISSUE cycles, response resp_lat
  // cycles after memReady (0 = same cycle).
  logic [31:0] mem_arr [0:255];
  int ready_delay = 0;
  int resp_lat = 1;
  bit rand_mem = 0;

  initial begin : mem_model
    int phase, wcnt, lcnt, cur_rd, cur_lat, idx;
    logic [31:0] rdat;
    phase = 0; wcnt = 0; lcnt = 0; cur_rd = 0; cur_lat = 0; rdat = '0;
    bus.memReady = 1'b0; bus.memRespValid = 1'b0; bus.memRespData = '0;
    forever begin
      @(negedge clk);
      bus.memReady = 1'b0;
      bus.memRespValid = 1'b0;
      if (!rst_n) begin
        phase = 0; wcnt = 0;
      end else if (phase == 1) begin
        lcnt--;
        if (lcnt <= 0) begin
          bus.memRespValid = 1'b1; bus.memRespData = rdat; phase = 0;
        end
      end else if (bus.memReqValid) begin
        if (wcnt == 0) begin
          cur_rd  = rand_mem ? int'($urandom_range(0, 2)) : ready_delay;
          cur_lat = rand_mem ? int'($urandom_range(0, 2)) : resp_lat;
        end
        if (wcnt < cur_rd) wcnt++;
        else begin
          wcnt = 0;
          bus.memReady = 1'b1;
          idx = int'(bus.memAddr[9:2]);
          if (bus.memWe)
            for (int b = 0; b < 4; b++)
              if (bus.memWstrb[b]) mem_arr[idx][8*b +: 8] = bus.memWdata[8*b +: 8];
          rdat = mem_arr[idx];
          if (cur_lat == 0) begin
            bus.memRespValid = 1'b1; bus.memRespData = rdat;
          end else begin
            phase = 1; lcnt = cur_lat;
          end
        end
      end
    end
  end

  typedef struct {bit is_d; logic [31:0] addr; bit we; logic [31:0] wdata; logic [3:0] wstrb; bit ival; bit dval;} gnt_t;
  typedef struct {bit is_d; logic [31:0] addr; logic [31:0] data;} rsp_t;
  gnt_t gq[$];
  rsp_t rq[$];
  bit mon_en = 0;

  initial begin : monitor
    gnt_t g;
    rsp_t r;
    forever begin
      @(negedge clk);
      #2;
      if (mon_en) begin
        if (bus.iReqValid && bus.iReqReady) begin
          g = '{0, bus.iReqAddr, 0, 32'd0, 4'd0, bus.iReqValid, bus.dReqValid}; gq.push_back(g);
        end
        if (bus.dReqValid && bus.dReqReady) begin
          g = '{1, bus.dReqAddr, bus.dReqWe, bus.dReqWdata, bus.dReqWstrb, bus.iReqValid, bus.dReqValid};
          gq.push_back(g);
        end
        if (bus.iRespValid) begin r = '{0, bus.iRespAddr, bus.iRespData}; rq.push_back(r); end
        if (bus.dRespValid) begin r = '{1, bus.dRespAddr, bus.dRespData}; rq.push_back(r); end
      end
    end
  end

  function automatic logic [201:0] all_outs();
    return {bus.iReqReady, bus.iRespValid, bus.iRespData, bus.iRespAddr,
            bus.dReqReady, bus.dRespValid, bus.dRespData, bus.dRespAddr,
            bus.memReqValid, bus.memAddr, bus.memWe, bus.memWdata, bus.memWstrb};
  endfunction

  task automatic do_reset();
    bus.iReqValid = 0; bus.iReqAddr = '0;
    bus.dReqValid = 0; bus.dReqAddr = '0; bus.dReqWe = 0; bus.dReqWdata = '0; bus.dReqWstrb = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.iReqValid = 1; bus.dReqValid = 1; bus.iReqAddr = 32'h40; bus.dReqAddr = 32'h44;
    bus.dReqWe = 0; bus.dReqWdata = '0; bus.dReqWstrb = '0;
    @(negedge clk); #2;
    checks++;
    if (all_outs() !== '0) begin failures++; $display("FAIL reset_outs got=%h want=0", all_outs()); end
    bus.iReqValid = 0; bus.dReqValid = 0;
    rst_n = 1'b1;
    @(negedge clk); #2;
    checks++;
    if (all_outs() !== '0) begin failures++; $display("FAIL post_reset_idle got=%h want=0", all_outs()); end
  endtask

  task automatic test_single_fetch();
    int pulses = 0, dpulses = 0;
    logic [31:0] rd = '0, ra = '0;
    do_reset(); ready_delay = 0; resp_lat = 1;
    mem_arr[1] = 32'h37010080;
    bus.iReqValid = 1; bus.iReqAddr = 32'h00000006;
    #1; checks++;
    if (bus.iReqReady !== 1'b1) begin failures++; $display("FAIL fetch_ready got=%b want=1", bus.iReqReady); end
    @(negedge clk); bus.iReqValid = 0; #2;
    checks++;
    if (bus.memReqValid !== 1'b1 || bus.memAddr !== 32'h4 || bus.memWe !== 1'b0 || bus.memWstrb !== 4'h0) begin
      failures++; $display("FAIL fetch_mem_req got v=%b a=%h we=%b want v=1 a=4 we=0", bus.memReqValid, bus.memAddr, bus.memWe);
    end
    for (int c = 0; c < 8; c++) begin
      @(negedge clk); #2;
      if (bus.iRespValid) begin pulses++; rd = bus.iRespData; ra = bus.iRespAddr; end
      if (bus.dRespValid) dpulses++;
    end
    checks++;
    if (pulses != 1 || dpulses != 0) begin failures++; $display("FAIL fetch_pulses got i=%0d d=%0d want i=1 d=0", pulses, dpulses); end
    checks++;
    if (rd !== 32'h37010080 || ra !== 32'h4) begin failures++; $display("FAIL fetch_resp got d=%h a=%h want d=37010080 a=4", rd, ra); end
  endtask

  task automatic test_priority();
    int early = 0, t = 0;
    bit seen = 0, rdy_at_resp = 0, iseen = 0;
    logic [31:0] dd = '0, id = '0, ia = '0;
    do_reset(); ready_delay = 0; resp_lat = 1;
    mem_arr[2] = 32'h0BADF00D; mem_arr[9] = 32'h24242424;
    bus.iReqValid = 1; bus.iReqAddr = 32'h8;
    bus.dReqValid = 1; bus.dReqAddr = 32'h24; bus.dReqWe = 0;
    #1; checks++;
    if ({bus.iReqReady, bus.dReqReady} !== 2'b01) begin
      failures++; $display("FAIL prio_first got i=%b d=%b want i=0 d=1", bus.iReqReady, bus.dReqReady);
    end
    @(negedge clk); bus.dReqValid = 0;
    // I must win in the first IDLE cycle, which is the one carrying dRespValid.
    while (!seen && t < 20) begin
      #1;
      if (bus.dRespValid) begin seen = 1; rdy_at_resp = bus.iReqReady; dd = bus.dRespData; end
      else begin
        if (bus.iReqReady) early++;
        @(negedge clk); t++;
      end
    end
    @(negedge clk); bus.iReqValid = 0;
    checks++;
    if (!seen || !rdy_at_resp || early != 0) begin
      failures++; $display("FAIL prio_i_after_d got seen=%b rdy=%b early=%0d want 1 1 0", seen, rdy_at_resp, early);
    end
    checks++;
    if (dd !== 32'h24242424) begin failures++; $display("FAIL prio_d_data got=%h want=24242424", dd); end
    for (int c = 0; c < 10 && !iseen; c++) begin
      #2; if (bus.iRespValid) begin iseen = 1; id = bus.iRespData; ia = bus.iRespAddr; end
      @(negedge clk);
    end
    checks++;
    if (!iseen || id !== 32'h0BADF00D || ia !== 32'h8) begin
      failures++; $display("FAIL prio_i_resp got seen=%b d=%h a=%h want 1 0badf00d 8", iseen, id, ia);
    end
  endtask

  task automatic test_starvation();
    string got = "", want = "";
    int both = 0, t = 0;
    do_reset(); ready_delay = 0; resp_lat = 0;
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < LIM; k++) want = {want, "D"};
      want = {want, "I"};
    end
    bus.iReqValid = 1; bus.iReqAddr = 32'h100;
    bus.dReqValid = 1; bus.dReqAddr = 32'h200; bus.dReqWe = 0;
    while (got.len() < want.len() && t < 300) begin
      #1;
      if (bus.iReqReady && bus.dReqReady) both++;
      if (bus.iReqReady) got = {got, "I"};
      else if (bus.dReqReady) got = {got, "D"};
      @(negedge clk); t++;
      bus.dReqAddr = bus.dReqAddr + 32'd4;
    end
    bus.iReqValid = 0; bus.dReqValid = 0;
    repeat (6) @(negedge clk);
    checks++;
    if (got != want || both != 0) begin failures++; $display("FAIL starve_seq got=%s want=%s both=%0d", got, want, both); end
  endtask

  task automatic test_store();
    int cnt = 0, bad = 0, pulses = 0;
    logic [31:0] dd = 32'hFFFFFFFF, da = '0;
    do_reset(); ready_delay = 3; resp_lat = 1;
    mem_arr[8] = 32'h11223344;
    bus.dReqValid = 1; bus.dReqAddr = 32'h20; bus.dReqWe = 1;
    bus.dReqWdata = 32'hDEADBEEF; bus.dReqWstrb = 4'h3;
    #1; checks++;
    if (bus.dReqReady !== 1'b1) begin failures++; $display("FAIL store_ready got=%b want=1", bus.dReqReady); end
    @(negedge clk); bus.dReqValid = 0; bus.dReqWe = 0; bus.dReqWdata = '0; bus.dReqWstrb = '0;
    for (int c = 0; c < 12; c++) begin
      #2;
      if (bus.memReqValid) begin
        cnt++;
        if (bus.memWe !== 1'b1 || bus.memAddr !== 32'h20 || bus.memWdata !== 32'hDEADBEEF || bus.memWstrb !== 4'h3) bad++;
      end
      if (bus.dRespValid) begin pulses++; dd = bus.dRespData; da = bus.dRespAddr; end
      @(negedge clk);
    end
    checks++;
    if (cnt != 4 || bad != 0) begin failures++; $display("FAIL store_hold got cycles=%0d bad=%0d want 4 0", cnt, bad); end
    checks++;
    if (pulses != 1 || dd !== 32'h0 || da !== 32'h20) begin
      failures++; $display("FAIL store_resp got n=%0d d=%h a=%h want 1 0 20", pulses, dd, da);
    end
    checks++;
    if (mem_arr[8] !== 32'h1122BEEF) begin failures++; $display("FAIL store_mem got=%h want=1122beef", mem_arr[8]); end
  endtask

  task automatic test_back_to_back();
    do_reset(); ready_delay = 0; resp_lat = 0;
    mem_arr[16] = 32'hA5A55A5A; mem_arr[3] = 32'hC0FFEE03;
    bus.dReqValid = 1; bus.dReqAddr = 32'h40; bus.dReqWe = 0;
    @(negedge clk); bus.dReqValid = 0; #2;
    checks++;
    if (bus.memReqValid !== 1'b1 || bus.memReady !== 1'b1 || bus.memRespValid !== 1'b1) begin
      failures++; $display("FAIL b2b_issue got v=%b rdy=%b rsp=%b want 1 1 1", bus.memReqValid, bus.memReady, bus.memRespValid);
    end
    @(negedge clk); #1;
    checks++;
    if (bus.dRespValid !== 1'b1 || bus.dRespData !== 32'hA5A55A5A || bus.memReqValid !== 1'b0) begin
      failures++; $display("FAIL b2b_dresp got v=%b d=%h mv=%b want 1 a5a55a5a 0", bus.dRespValid, bus.dRespData, bus.memReqValid);
    end
    bus.iReqValid = 1; bus.iReqAddr = 32'hC;
    #1; checks++;
    if (bus.iReqReady !== 1'b1) begin failures++; $display("FAIL b2b_accept got=%b want=1", bus.iReqReady); end
    @(negedge clk); bus.iReqValid = 0; #2;
    checks++;
    if (bus.memReqValid !== 1'b1 || bus.memAddr !== 32'hC || bus.dRespValid !== 1'b0) begin
      failures++; $display("FAIL b2b_second got v=%b a=%h dv=%b want 1 c 0", bus.memReqValid, bus.memAddr, bus.dRespValid);
    end
    @(negedge clk); #2;
    checks++;
    if (bus.iRespValid !== 1'b1 || bus.iRespData !== 32'hC0FFEE03) begin
      failures++; $display("FAIL b2b_iresp got v=%b d=%h want 1 c0ffee03", bus.iRespValid, bus.iRespData);
    end
  endtask

  task automatic test_reset_mid();
    int stray = 0;
    bit iseen = 0;
    logic [31:0] id = '0, ia = 32'hFFFFFFFF;
    do_reset(); ready_delay = 5; resp_lat = 1;
    bus.dReqValid = 1; bus.dReqAddr = 32'h10; bus.dReqWe = 0;
    @(negedge clk); bus.dReqValid = 0;
    @(negedge clk);
    rst_n = 1'b0; #1;
    checks++;
    if (bus.memReqValid !== 1'b0) begin failures++; $display("FAIL rst_issue_drop got=%b want=0", bus.memReqValid); end
    @(negedge clk); rst_n = 1'b1;
    ready_delay = 0; resp_lat = 50;
    bus.dReqValid = 1;
    @(negedge clk); bus.dReqValid = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0; #1;
    checks++;
    if (all_outs() !== '0) begin failures++; $display("FAIL rst_wait_outs got=%h want=0", all_outs()); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin #2; if (bus.dRespValid || bus.iRespValid) stray++; @(negedge clk); end
    checks++;
    if (stray != 0) begin failures++; $display("FAIL rst_no_resp got=%0d want=0", stray); end
    resp_lat = 1; mem_arr[0] = 32'h13579BDF;
    bus.iReqValid = 1; bus.iReqAddr = 32'h0;
    @(negedge clk); bus.iReqValid = 0;
    for (int c = 0; c < 10 && !iseen; c++) begin
      #2; if (bus.iRespValid) begin iseen = 1; id = bus.iRespData; ia = bus.iRespAddr; end
      @(negedge clk);
    end
    checks++;
    if (!iseen || id !== 32'h13579BDF || ia !== 32'h0) begin
      failures++; $display("FAIL rst_then_fetch got seen=%b d=%h a=%h want 1 13579bdf 0", iseen, id, ia);
    end
  endtask

  task automatic drv_i(input int n);
    int t;
    for (int k = 0; k < n; k++) begin
      bus.iReqValid = 1; bus.iReqAddr = 32'($urandom_range(0, 1023));
      t = 0;
      #1;
      while (!bus.iReqReady && t < 200) begin @(negedge clk); #1; t++; end
      if (t >= 200) begin failures++; $display("FAIL rand_i_timeout got=no_grant want=grant"); end
      @(negedge clk); bus.iReqValid = 0;
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  task automatic drv_d(input int n);
    int t;
    for (int k = 0; k < n; k++) begin
      bus.dReqValid = 1; bus.dReqAddr = 32'($urandom_range(0, 1023));
      bus.dReqWe = ($urandom_range(0, 2) == 0); bus.dReqWdata = $urandom; bus.dReqWstrb = 4'($urandom_range(0, 15));
      t = 0;
      #1;
      while (!bus.dReqReady && t < 200) begin @(negedge clk); #1; t++; end
      if (t >= 200) begin failures++; $display("FAIL rand_d_timeout got=no_grant want=grant"); end
      @(negedge clk); bus.dReqValid = 0;
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  task automatic test_random();
    localparam int N = 25;
    logic [31:0] sh [0:255];
    int cnt = 0, idx;
    bit exp_d;
    logic [31:0] eaddr, edata;
    do_reset();
    for (int w = 0; w < 256; w++) begin mem_arr[w] = $urandom; sh[w] = mem_arr[w]; end
    gq.delete(); rq.delete();
    rand_mem = 1; mon_en = 1;
    fork
      drv_i(N);
      drv_d(N);
    join
    repeat (10) @(negedge clk);
    mon_en = 0; rand_mem = 0;
    checks++;
    if (gq.size() != 2*N || rq.size() != 2*N) begin
      failures++; $display("FAIL rand_counts got g=%0d r=%0d want %0d", gq.size(), rq.size(), 2*N);
    end
    // Reference: D wins unless I has waited through LIM straight D grants.
    foreach (gq[k]) begin
      exp_d = !(gq[k].ival && (!gq[k].dval || cnt >= LIM));
      checks++;
      if (gq[k].is_d != exp_d) begin failures++; $display("FAIL rand_winner #%0d got d=%b want d=%b cnt=%0d", k, gq[k].is_d, exp_d, cnt); end
      if (!exp_d || !gq[k].ival) cnt = 0;
      else if (cnt < 15) cnt++;
      idx = int'(gq[k].addr[9:2]);
      if (!gq[k].is_d) begin
        eaddr = {gq[k].addr[31:2], 2'b00}; edata = sh[idx];
      end else begin
        eaddr = gq[k].addr; edata = sh[idx];
        if (gq[k].we) begin
          for (int b = 0; b < 4; b++) if (gq[k].wstrb[b]) sh[idx][8*b +: 8] = gq[k].wdata[8*b +: 8];
          edata = '0;
        end
      end
      if (k < rq.size()) begin
        checks++;
        if (rq[k].is_d != gq[k].is_d || rq[k].addr !== eaddr || rq[k].data !== edata) begin
          failures++;
          $display("FAIL rand_resp #%0d got d=%b a=%h v=%h want d=%b a=%h v=%h", k, rq[k].is_d, rq[k].addr, rq[k].data, gq[k].is_d, eaddr, edata);
        end
      end
    end
  endtask

  initial begin
    bus.iReqValid = 0; bus.iReqAddr = '0;
    bus.dReqValid = 0; bus.dReqAddr = '0; bus.dReqWe = 0; bus.dReqWdata = '0; bus.dReqWstrb = '0;
    for (int w = 0; w < 256; w++) mem_arr[w] = 32'h0;
    test_reset();
    test_single_fetch();
    test_priority();
    test_starvation();
    test_store();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end
endmodule
